// File: rtl/ram_pkg.sv
// Shared constants and helpers for the RAM-based FIFO slice.
// Read latency selection and a constant-friendly log2.
package ram_pkg;

    localparam string REGMODE_REG   = "REG";
    localparam string REGMODE_NOREG = "NOREG";

    function automatic int rd_latency(input string mode);
        return (mode == REGMODE_NOREG) ? 1 : 2;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_pdp_sc.sv
// Single-clock simple dual-port RAM, one write and one read port.
// Optional output register maps onto the block RAM's own pipeline stage.
import ram_pkg::*;

module ram_pdp_sc #(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 10,
    parameter string REGMODE    = "REG"
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LAT   = rd_latency(REGMODE);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd1_q;

    // Contents are deliberately never cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rd1_q <= mem_q[raddr_i];
        end
    end

    if (LAT == 2) begin : g_outreg
        logic [DATA_WIDTH-1:0] rd2_q;

        always_ff @(posedge clk_i) begin
            rd2_q <= rd1_q;
        end

        assign rdata_o = rd2_q;
    end else begin : g_noreg
        assign rdata_o = rd1_q;
    end

endmodule

// File: rtl/ram_pdp_fifo.sv
// First-word-fall-through FIFO on a simple dual-port RAM with
// a prefetching skid stage sized to the RAM read latency.
import ram_pkg::*;

module ram_pdp_fifo #(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 10,
    parameter string REGMODE    = "REG",
    parameter int    AF_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int    AE_THRESH  = 4
) (
    input  logic                  CLK,
    input  logic                  SRST_N,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LAT   = rd_latency(REGMODE);
    localparam int Q     = LAT + 1;
    localparam int CW    = clog2(Q + 1);

    typedef logic [ADDR_WIDTH:0] lvl_t;

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    lvl_t                  level_q, level_d;
    logic [CW-1:0]         scnt_q, scnt_d;
    logic [DATA_WIDTH-1:0] sk_q [Q];
    logic [DATA_WIDTH-1:0] sk_d [Q];
    logic [LAT-1:0]        rv_q, rv_d;
    logic                  full_q, full_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  push, pop, issue, arrive;
    lvl_t                  inflight, held, ram_avail;
    logic [DATA_WIDTH-1:0] ram_rdata;

    ram_pdp_sc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REGMODE    (REGMODE)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (WR_DATA),
        .re_i    (issue),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    // Words held outside the RAM: output stage, skid and in-flight reads.
    always_comb begin
        push   = WR_EN & ~full_q;
        pop    = RD_EN & (scnt_q != '0);
        arrive = rv_q[LAT-1];

        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + lvl_t'(rv_q[i]);
        end
        held      = lvl_t'(scnt_q) + inflight;
        ram_avail = level_q - held;

        // A pop this cycle frees a slot, keeping reads back-to-back.
        issue = (ram_avail != '0) &&
                (held < (lvl_t'(Q) + lvl_t'(pop)));
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
        if (issue) begin
            rptr_d = rptr_q + ADDR_WIDTH'(1);
        end

        level_d = level_q + lvl_t'(push) - lvl_t'(pop);

        rv_d    = '0;
        rv_d[0] = issue;
        for (int i = 1; i < LAT; i++) begin
            rv_d[i] = rv_q[i-1];
        end
    end

    // Shift-register skid; slot 0 is the output stage.
    always_comb begin
        sk_d   = sk_q;
        scnt_d = scnt_q;
        if (pop) begin
            for (int i = 0; i < Q - 1; i++) begin
                sk_d[i] = sk_q[i+1];
            end
            scnt_d = scnt_q - CW'(1);
        end
        if (arrive) begin
            for (int i = 0; i < Q; i++) begin
                if (CW'(i) == scnt_d) begin
                    sk_d[i] = ram_rdata;
                end
            end
            scnt_d = scnt_d + CW'(1);
        end
    end

    always_comb begin
        full_d = (level_d == lvl_t'(DEPTH));
        af_d   = (level_d >= lvl_t'(AF_THRESH));
        ae_d   = (level_d <= lvl_t'(AE_THRESH));
        ovf_d  = WR_EN & full_q;
        unf_d  = RD_EN & (scnt_q == '0);
    end

    always_ff @(posedge CLK) begin
        if (!SRST_N) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            scnt_q  <= '0;
            rv_q    <= '0;
            for (int i = 0; i < Q; i++) begin
                sk_q[i] <= '0;
            end
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            scnt_q  <= scnt_d;
            rv_q    <= rv_d;
            for (int i = 0; i < Q; i++) begin
                sk_q[i] <= sk_d[i];
            end
            full_q  <= full_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign RD_DATA      = sk_q[0];
    assign RD_VALID     = (scnt_q != '0);
    assign FULL         = full_q;
    assign ALMOST_FULL  = af_q;
    assign ALMOST_EMPTY = ae_q;
    assign LEVEL        = level_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_ram_pdp_fifo.sv
// Directed bench for ram_pdp_fifo: 16-deep, registered RAM output.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ram_pdp_fifo;

    logic        CLK = 1'b0;
    logic        SRST_N;
    logic        WR_EN;
    logic [15:0] WR_DATA;
    logic        RD_EN;
    logic [15:0] RD_DATA;
    logic        RD_VALID;
    logic        FULL;
    logic        ALMOST_FULL;
    logic        ALMOST_EMPTY;
    logic [4:0]  LEVEL;
    logic        OVERFLOW;
    logic        UNDERFLOW;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    ram_pdp_fifo #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .REGMODE    ("REG")
    ) dut (
        .CLK          (CLK),
        .SRST_N       (SRST_N),
        .WR_EN        (WR_EN),
        .WR_DATA      (WR_DATA),
        .RD_EN        (RD_EN),
        .RD_DATA      (RD_DATA),
        .RD_VALID     (RD_VALID),
        .FULL         (FULL),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .LEVEL        (LEVEL),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        SRST_N  = 1'b0;
        WR_EN   = 1'b1;
        RD_EN   = 1'b1;
        WR_DATA = 16'h5555;
        tick();
        tick();
        chk("rst_valid", 32'(RD_VALID), 32'd0);
        chk("rst_data", 32'(RD_DATA), 32'd0);
        chk("rst_level", 32'(LEVEL), 32'd0);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_af", 32'(ALMOST_FULL), 32'd0);
        chk("rst_ae", 32'(ALMOST_EMPTY), 32'd1);
        chk("rst_ovf", 32'(OVERFLOW), 32'd0);
        chk("rst_unf", 32'(UNDERFLOW), 32'd0);

        WR_EN  = 1'b0;
        RD_EN  = 1'b0;
        SRST_N = 1'b1;
        tick();

        // first word shows up three edges after it is pushed
        for (int i = 1; i <= 4; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = 16'(i);
            tick();
            if (i < 4) chk("lat_valid_low", 32'(RD_VALID), 32'd0);
        end
        chk("lat_valid_rise", 32'(RD_VALID), 32'd1);
        chk("lat_data", 32'(RD_DATA), 32'h0001);
        chk("lat_level", 32'(LEVEL), 32'd4);
        chk("ae_at_4", 32'(ALMOST_EMPTY), 32'd1);

        for (int i = 5; i <= 16; i++) begin
            WR_DATA = 16'(i);
            tick();
            chk("fill_level", 32'(LEVEL), 32'(i));
            if (i == 5)  chk("ae_at_5", 32'(ALMOST_EMPTY), 32'd0);
            if (i == 11) chk("af_at_11", 32'(ALMOST_FULL), 32'd0);
            if (i == 12) chk("af_at_12", 32'(ALMOST_FULL), 32'd1);
            if (i == 15) chk("full_at_15", 32'(FULL), 32'd0);
        end
        chk("full_at_16", 32'(FULL), 32'd1);
        chk("hold_data", 32'(RD_DATA), 32'h0001);

        WR_DATA = 16'hBEEF;
        tick();
        chk("ovf_pulse", 32'(OVERFLOW), 32'd1);
        chk("ovf_level", 32'(LEVEL), 32'd16);
        chk("ovf_full", 32'(FULL), 32'd1);
        WR_EN = 1'b0;
        tick();
        chk("ovf_once", 32'(OVERFLOW), 32'd0);
        chk("ovf_level2", 32'(LEVEL), 32'd16);

        // push and pop together while full: pop only
        WR_EN   = 1'b1;
        WR_DATA = 16'h00AA;
        RD_EN   = 1'b1;
        tick();
        chk("fullpp_level", 32'(LEVEL), 32'd15);
        chk("fullpp_full", 32'(FULL), 32'd0);
        chk("fullpp_data", 32'(RD_DATA), 32'h0002);
        chk("fullpp_ovf", 32'(OVERFLOW), 32'd1);
        RD_EN   = 1'b0;
        WR_DATA = 16'h0011;
        tick();
        chk("refill_level", 32'(LEVEL), 32'd16);
        chk("refill_full", 32'(FULL), 32'd1);
        chk("refill_ovf", 32'(OVERFLOW), 32'd0);
        WR_EN = 1'b0;

        for (int i = 0; i < 16; i++) begin
            RD_EN = 1'b1;
            chk("drain_valid", 32'(RD_VALID), 32'd1);
            chk("drain_data", 32'(RD_DATA),
                (i < 15) ? 32'(i + 2) : 32'h0011);
            tick();
        end
        RD_EN = 1'b0;
        chk("drained_level", 32'(LEVEL), 32'd0);
        chk("drained_valid", 32'(RD_VALID), 32'd0);
        chk("drained_ae", 32'(ALMOST_EMPTY), 32'd1);

        RD_EN = 1'b1;
        tick();
        chk("unf_pulse", 32'(UNDERFLOW), 32'd1);
        chk("unf_level", 32'(LEVEL), 32'd0);
        chk("unf_valid", 32'(RD_VALID), 32'd0);
        RD_EN = 1'b0;
        tick();
        chk("unf_once", 32'(UNDERFLOW), 32'd0);

        // push and pop together while empty: push only
        WR_EN   = 1'b1;
        RD_EN   = 1'b1;
        WR_DATA = 16'h0C0D;
        tick();
        chk("emptypp_level", 32'(LEVEL), 32'd1);
        chk("emptypp_unf", 32'(UNDERFLOW), 32'd1);
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        tick();
        tick();
        chk("emptypp_notyet", 32'(RD_VALID), 32'd0);
        tick();
        chk("emptypp_valid", 32'(RD_VALID), 32'd1);
        chk("emptypp_data", 32'(RD_DATA), 32'h0C0D);
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        chk("emptypp_popped", 32'(LEVEL), 32'd0);
        chk("emptypp_gone", 32'(RD_VALID), 32'd0);

        for (int i = 0; i < 4; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = 16'(16'h0100 + i);
            tick();
        end
        chk("prime_valid", 32'(RD_VALID), 32'd1);
        chk("prime_level", 32'(LEVEL), 32'd4);

        for (int i = 0; i < 100; i++) begin
            WR_DATA = 16'(16'h0104 + i);
            RD_EN   = 1'b1;
            chk("stream_valid", 32'(RD_VALID), 32'd1);
            chk("stream_data", 32'(RD_DATA), 32'(16'h0100 + i));
            tick();
            chk("stream_level", 32'(LEVEL), 32'd4);
        end
        WR_EN = 1'b0;
        RD_EN = 1'b0;

        SRST_N = 1'b0;
        tick();
        SRST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = 16'(16'h00D1 + i);
            tick();
        end
        WR_EN  = 1'b0;
        SRST_N = 1'b0;
        tick();
        chk("midrst_valid", 32'(RD_VALID), 32'd0);
        chk("midrst_level", 32'(LEVEL), 32'd0);
        chk("midrst_data", 32'(RD_DATA), 32'd0);
        chk("midrst_ae", 32'(ALMOST_EMPTY), 32'd1);
        SRST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stale_valid", 32'(RD_VALID), 32'd0);
            chk("stale_level", 32'(LEVEL), 32'd0);
        end

        WR_EN   = 1'b1;
        WR_DATA = 16'h0E0E;
        tick();
        WR_EN = 1'b0;
        tick();
        tick();
        tick();
        chk("post_valid", 32'(RD_VALID), 32'd1);
        chk("post_data", 32'(RD_DATA), 32'h0E0E);
        chk("post_level", 32'(LEVEL), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
